// File: rtl/instr_fetch_decode_pkg.sv
// Shared CPU front-end constants: opcodes, instruction field positions,
// fetch/decode FSM state encoding and small field-extraction helpers.
package instr_fetch_decode_pkg;

    localparam int unsigned PC_WIDTH_DEF    = 8;
    localparam int unsigned INSTR_WIDTH_DEF = 8;
    localparam int unsigned CNT_WIDTH_DEF   = 16;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Instruction field map: [7:5] operation, [4:3] rd, [2:1] rs, [0] reserved
    localparam int unsigned IR_OP_MSB = 7;
    localparam int unsigned IR_OP_LSB = 5;
    localparam int unsigned IR_RD_MSB = 4;
    localparam int unsigned IR_RD_LSB = 3;
    localparam int unsigned IR_RS_MSB = 2;
    localparam int unsigned IR_RS_LSB = 1;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    function automatic logic [2:0] ir_op(input logic [INSTR_WIDTH_DEF-1:0] ir);
        return ir[IR_OP_MSB:IR_OP_LSB];
    endfunction

    function automatic logic [1:0] ir_rd(input logic [INSTR_WIDTH_DEF-1:0] ir);
        return ir[IR_RD_MSB:IR_RD_LSB];
    endfunction

    function automatic logic [1:0] ir_rs(input logic [INSTR_WIDTH_DEF-1:0] ir);
        return ir[IR_RS_MSB:IR_RS_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory handshake plus decoded-instruction bus of the fetch/decode stage.
// master = fetch/decode unit, slave = memory/execute side.
interface instr_fetch_decode_if
    import instr_fetch_decode_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [2:0]             operation;
    logic [1:0]             rd_addr;
    logic [1:0]             rs_addr;
    logic                   dec_valid;
    logic                   dec_ready;
    logic                   halted;
    logic [PC_WIDTH-1:0]    pc;
    logic [CNT_WIDTH-1:0]   instr_count;

    modport master (
        output imem_req, imem_addr, operation, rd_addr, rs_addr,
               dec_valid, halted, pc, instr_count,
        input  imem_ack, imem_rdata, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, operation, rd_addr, rs_addr,
               dec_valid, halted, pc, instr_count,
        output imem_ack, imem_rdata, dec_ready
    );
endinterface

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: owns PC and IR, fetches over req/ack, presents decoded
// fields to execute with valid/ready, stops on HALT. IFD_JUMP_EN adds a jump port.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
`ifdef IFD_JUMP_EN
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
`endif
    instr_fetch_decode_if.master bus
);

    logic [1:0]             state_q,  state_d;
    logic [PC_WIDTH-1:0]    pc_q,     pc_d;
    logic [INSTR_WIDTH-1:0] ir_q,     ir_d;
    logic                   req_q,    req_d;
    logic                   valid_q,  valid_d;
    logic                   halted_q, halted_d;
    logic [CNT_WIDTH-1:0]   cnt_q,    cnt_d;
    logic                   ir_rsvd_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and next-output logic; request is raised one edge after entering FETCH idle
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_FETCH: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (bus.dec_ready) begin
                    valid_d = 1'b0;
                    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                    if (ir_q[IR_OP_MSB:IR_OP_LSB] == OP_HALT) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase

`ifdef IFD_JUMP_EN
        // Jump overrides any same-cycle ack (data dropped) or retire
        if (jump_valid) begin
            pc_d     = jump_target;
            ir_d     = ir_q;
            cnt_d    = cnt_q;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            req_d    = 1'b1;
            state_d  = ST_FETCH;
        end
`endif
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.operation   = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign bus.rd_addr     = ir_q[IR_RD_MSB:IR_RD_LSB];
    assign bus.rs_addr     = ir_q[IR_RS_MSB:IR_RS_LSB];
    assign bus.dec_valid   = valid_q;
    assign bus.halted      = halted_q;
    assign bus.pc          = pc_q;
    assign bus.instr_count = cnt_q;

    // IR[0] is reserved and intentionally not decoded
    assign ir_rsvd_unused = ir_q[0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed self-checking bench for instr_fetch_decode with an expected-decode scoreboard.
module tb_instr_fetch_decode;
    import instr_fetch_decode_pkg::*;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    logic       jump_valid;
    logic [7:0] jump_target;

    instr_fetch_decode_if #(.PC_WIDTH(8), .INSTR_WIDTH(8), .CNT_WIDTH(16)) bus ();

    instr_fetch_decode #(.PC_WIDTH(8), .INSTR_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef IFD_JUMP_EN
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
`endif
        .bus         (bus.master)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [7:0]  exp_pc  = 8'h00;
    logic [15:0] exp_cnt = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] data, input int delay);
        int n;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_req", 32'(bus.imem_req), 1);
        chk("fetch_addr", 32'(bus.imem_addr), 32'(exp_pc));
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("req_hold", 32'(bus.imem_req), 1);
            chk("addr_hold", 32'(bus.imem_addr), 32'(exp_pc));
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        exp_pc = exp_pc + 8'd1;
        sb.push_back('{op: data[7:5], rd: data[4:3], rs: data[2:1], pc: exp_pc});
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 8'($urandom);
        chk("req_drop", 32'(bus.imem_req), 0);
    endtask

    task automatic decode(input int stall);
        exp_t e;
        logic hlt;
        chk("dec_valid", 32'(bus.dec_valid), 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            chk("operation", 32'(bus.operation), 32'(e.op));
            chk("rd_addr", 32'(bus.rd_addr), 32'(e.rd));
            chk("rs_addr", 32'(bus.rs_addr), 32'(e.rs));
            chk("pc", 32'(bus.pc), 32'(e.pc));
            for (int i = 0; i < stall; i++) begin
                tick();
                chk("stall_valid", 32'(bus.dec_valid), 1);
                chk("stall_op", 32'(bus.operation), 32'(e.op));
                chk("stall_rd", 32'(bus.rd_addr), 32'(e.rd));
                chk("stall_rs", 32'(bus.rs_addr), 32'(e.rs));
                chk("stall_noreq", 32'(bus.imem_req), 0);
            end
            hlt = (e.op == OP_HALT);
            bus.dec_ready = 1'b1;
            tick();
            bus.dec_ready = 1'b0;
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            chk("retire_valid", 32'(bus.dec_valid), 0);
            chk("instr_count", 32'(bus.instr_count), 32'(exp_cnt));
            chk("rereq", 32'(bus.imem_req), 32'(!hlt));
            chk("halted", 32'(bus.halted), 32'(hlt));
        end
    endtask

    function automatic logic [7:0] rand_instr();
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        return {op, 5'($urandom)};
    endfunction

    initial begin
        rst = 1'b0;
        jump_valid = 1'b0;
        jump_target = 8'h00;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 8'h00;
        bus.dec_ready = 1'b0;

        // Reset asserted between edges clears everything without a clock
        #2 rst = 1'b1;
        #1;
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_pc", 32'(bus.pc), 0);
        chk("rst_valid", 32'(bus.dec_valid), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_cnt", 32'(bus.instr_count), 0);
        chk("rst_op", 32'(bus.operation), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_req", 32'(bus.imem_req), 1);
        chk("post_rst_addr", 32'(bus.imem_addr), 0);

        // Mid-fetch reset pulse with a pending ack: abandoned, not consumed
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 8'h5A;
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus.imem_req), 0);
        chk("mid_rst_valid", 32'(bus.dec_valid), 0);
        tick();
        bus.imem_ack = 1'b0;
        rst = 1'b0;
        chk("mid_rst_hold_req", 32'(bus.imem_req), 0);
        tick();
        chk("rerelease_req", 32'(bus.imem_req), 1);
        chk("rerelease_addr", 32'(bus.imem_addr), 0);
        chk("rerelease_valid", 32'(bus.dec_valid), 0);

        // SUB rd=1 rs=1, with a 5-cycle decode stall
        fetch(8'h2A, 0);
        decode(5);

        // Delayed ack
        fetch(rand_instr(), 4);
        decode(1);

        // Run up to the PC wrap point
        while (exp_pc != 8'hFF) begin
            fetch(rand_instr(), 0);
            decode(0);
        end
        fetch(rand_instr(), 2);
        chk("pc_wrap", 32'(bus.pc), 0);
        decode(0);

        // HALT: sticky, stray acks ignored
        fetch(8'hE0, 1);
        decode(2);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_noreq", 32'(bus.imem_req), 0);
            chk("halt_sticky", 32'(bus.halted), 1);
            chk("halt_novalid", 32'(bus.dec_valid), 0);
            chk("halt_pc", 32'(bus.pc), 32'(exp_pc));
            chk("halt_op", 32'(bus.operation), 32'(OP_HALT));
        end
        bus.imem_ack = 1'b0;

`ifdef IFD_JUMP_EN
        // Jump out of HALT resumes fetching at the target
        jump_valid = 1'b1;
        jump_target = 8'h10;
        tick();
        jump_valid = 1'b0;
        exp_pc = 8'h10;
        chk("jmp_halted", 32'(bus.halted), 0);
        chk("jmp_req", 32'(bus.imem_req), 1);
        chk("jmp_addr", 32'(bus.imem_addr), 32'(exp_pc));

        // Jump in the same cycle as ack drops the fetched data
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 8'h2A;
        jump_valid = 1'b1;
        jump_target = 8'h40;
        tick();
        bus.imem_ack = 1'b0;
        jump_valid = 1'b0;
        exp_pc = 8'h40;
        chk("jmp_ack_valid", 32'(bus.dec_valid), 0);
        chk("jmp_ack_req", 32'(bus.imem_req), 1);
        chk("jmp_ack_addr", 32'(bus.imem_addr), 32'(exp_pc));
        chk("jmp_ack_cnt", 32'(bus.instr_count), 32'(exp_cnt));
        fetch(8'h44, 0);
        decode(0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
